// File: rtl/aes_pkg.sv
// Shared types, mode encodings and key-schedule helpers for the AES key expander.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] ModeAes128    = 2'd0;
  localparam logic [1:0] ModeAes192    = 2'd1;
  localparam logic [1:0] ModeAes256    = 2'd2;
  localparam logic [1:0] ModeAes128Alt = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      ModeAes192: nk_of = 4'd6;
      ModeAes256: nk_of = 4'd8;
      default:    nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      ModeAes192: nr_of = 4'd12;
      ModeAes256: nr_of = 4'd14;
      default:    nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic word_t rot_word(input word_t w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
  always_comb begin
    w_sq  = gf_mul(i_byte, i_byte);
    w_inv = w_sq;
    for (int k = 1; k < 7; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                  {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule; streams one 128-bit round key per handshake.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter logic [2:0] MODE_EN = 3'b111
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  input  logic [255:0] i_key_in,
  output logic         o_busy,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic [127:0] o_rk_data,
  output logic [3:0]   o_rk_index,
  output logic         o_done,
  output logic         o_err
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [1:0]   r_mode;
  word_t        r_win [8];
  logic [1:0]   r_lane;
  logic [2:0]   r_kcnt;
  logic [3:0]   r_rci;
  logic         r_rk_valid;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_index;
  logic         r_err;

  logic         w_mode_ok;
  logic [1:0]   w_mode_norm;
  logic         w_accept;
  logic         w_reject;
  logic         w_gen;
  logic         w_hs;
  logic [3:0]   w_nk;
  logic [3:0]   w_nr;
  logic [2:0]   w_kcnt_last;
  logic [2:0]   w_old_idx;
  word_t        w_prev;
  word_t        w_sub_in;
  word_t        w_sub_out;
  word_t        w_temp;
  word_t        w_word;

  always_comb begin
    case (i_mode)
      ModeAes192: w_mode_ok = MODE_EN[1];
      ModeAes256: w_mode_ok = MODE_EN[2];
      default:    w_mode_ok = MODE_EN[0];
    endcase
  end

  assign w_mode_norm = (i_mode == ModeAes128Alt) ? ModeAes128 : i_mode;
  assign w_accept    = (r_state == StIdle) && i_start && w_mode_ok;
  assign w_reject    = (r_state == StIdle) && i_start && !w_mode_ok;
  assign w_gen       = (r_state == StRun) && !r_rk_valid;
  assign w_hs        = r_rk_valid && i_rk_ready;
  assign w_nk        = nk_of(r_mode);
  assign w_nr        = nr_of(r_mode);
  assign w_kcnt_last = 3'(w_nk - 4'd1);

  // Every word, key words included, is shifted through the window, so
  // r_win[7] is always w[i-1] and r_win[8-Nk] is always w[i-Nk].
  assign w_old_idx = 3'(4'd8 - w_nk);
  assign w_prev    = r_win[7];
  assign w_sub_in  = (r_kcnt == 3'd0) ? rot_word(w_prev) : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(w_sub_in[8*g +: 8]),
      .o_byte(w_sub_out[8*g +: 8])
    );
  end

  always_comb begin
    w_temp = w_prev;
    if (r_kcnt == 3'd0) begin
      w_temp = w_sub_out ^ {rcon(r_rci), 24'h0};
    end else if (w_nk == 4'd8 && r_kcnt == 3'd4) begin
      w_temp = w_sub_out;
    end
    // r_rci == 0 means i < Nk: the word is still coming out of the key itself.
    w_word = (r_rci == 4'd0) ? r_win[0] : (r_win[w_old_idx] ^ w_temp);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StRun;
      StRun:   if (w_hs && r_rk_index == w_nr) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_mode  <= ModeAes128;
      for (int j = 0; j < 8; j++) r_win[j] <= '0;
      r_lane     <= '0;
      r_kcnt     <= '0;
      r_rci      <= '0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_accept) begin
        r_mode <= w_mode_norm;
        for (int j = 0; j < 8; j++) r_win[j] <= i_key_in[255 - 32*j -: 32];
        r_lane     <= '0;
        r_kcnt     <= '0;
        r_rci      <= '0;
        r_rk_index <= '0;
      end
      if (w_gen) begin
        for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
        r_win[7] <= w_word;
        unique case (r_lane)
          2'd0: r_rk_data[127:96] <= w_word;
          2'd1: r_rk_data[95:64]  <= w_word;
          2'd2: r_rk_data[63:32]  <= w_word;
          2'd3: r_rk_data[31:0]   <= w_word;
        endcase
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) r_rk_valid <= 1'b1;
        if (r_kcnt == w_kcnt_last) begin
          r_kcnt <= '0;
          r_rci  <= r_rci + 4'd1;
        end else begin
          r_kcnt <= r_kcnt + 3'd1;
        end
      end
      if (w_hs) begin
        r_rk_valid <= 1'b0;
        if (r_rk_index != w_nr) r_rk_index <= r_rk_index + 4'd1;
      end
    end
  end

  assign o_busy     = (r_state == StRun);
  assign o_done     = (r_state == StDone);
  assign o_rk_valid = r_rk_valid;
  assign o_rk_data  = r_rk_data;
  assign o_rk_index = r_rk_index;
  assign o_err      = r_err;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
module tb_aes_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         start2;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         rk_ready;
  logic         busy, rk_valid, done, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy2, rk_valid2, done2, err2;
  logic [127:0] rk_data2;
  logic [3:0]   rk_index2;

  int n_err = 0;
  int n_chk = 0;

  logic [127:0] got [0:15];
  logic [127:0] exp128 [0:10];
  int n_hs;
  int cyc_done;
  int stall_bad;
  int idx_bad;

  localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] Key192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expander #(.MODE_EN(3'b111)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_key_in(key_in),
    .o_busy(busy), .o_rk_valid(rk_valid), .i_rk_ready(rk_ready), .o_rk_data(rk_data),
    .o_rk_index(rk_index), .o_done(done), .o_err(err)
  );

  aes_key_expander #(.MODE_EN(3'b011)) dut_lim (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_mode(mode), .i_key_in(key_in),
    .o_busy(busy2), .o_rk_valid(rk_valid2), .i_rk_ready(rk_ready), .o_rk_data(rk_data2),
    .o_rk_index(rk_index2), .o_done(done2), .o_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs one expansion; inputs change and outputs are sampled on the falling edge.
  task automatic run_exp(input logic [1:0] m, input logic [255:0] k, input int ready_pct,
                         input bit disturb);
    int cyc;
    bit rdy;
    bit prev_stall;
    logic [127:0] prev_data;
    logic [3:0] prev_idx;
    n_hs = 0; cyc_done = -1; stall_bad = 0; idx_bad = 0; prev_stall = 1'b0;
    prev_data = '0; prev_idx = '0;
    for (int j = 0; j < 16; j++) got[j] = '0;
    @(negedge clk);
    start = 1'b1; mode = m; key_in = k;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      if (done) begin
        cyc_done = cyc;
        break;
      end
      if (prev_stall && (!rk_valid || rk_data !== prev_data || rk_index !== prev_idx))
        stall_bad++;
      rdy = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      rk_ready = rdy;
      if (rk_valid && rdy) begin
        if (n_hs < 16) got[n_hs] = rk_data;
        if (rk_index !== 4'(n_hs)) idx_bad++;
        n_hs++;
      end
      prev_stall = rk_valid && !rdy;
      prev_data = rk_data;
      prev_idx = rk_index;
      if (disturb) begin
        start = ((cyc % 7) == 3);
        mode = 2'($urandom);
        for (int j = 0; j < 8; j++) key_in[32*j +: 32] = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic chk_sched128(input string tag);
    for (int r = 0; r <= 10; r++) chk($sformatf("%s_rk%0d", tag, r), got[r], exp128[r]);
  endtask

  initial begin
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 2'd0; key_in = '0; rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_rk_data", rk_data, 128'(0));
    chk("rst_rk_index", 128'(rk_index), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128, full-rate consumer
    run_exp(2'd0, Key128, 100, 1'b0);
    chk_sched128("a128");
    chk("a128_handshakes", 128'(n_hs), 128'(11));
    chk("a128_latency", 128'(cyc_done), 128'(55));
    chk("a128_busy_at_done", 128'(busy), 128'(0));
    chk("a128_idx_seq", 128'(idx_bad), 128'(0));
    @(negedge clk);
    chk("a128_done_one_cycle", 128'(done), 128'(0));

    // AES-192
    run_exp(2'd1, Key192, 100, 1'b0);
    chk("a192_rk0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("a192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("a192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("a192_handshakes", 128'(n_hs), 128'(13));
    chk("a192_latency", 128'(cyc_done), 128'(65));

    // AES-256
    run_exp(2'd2, Key256, 100, 1'b0);
    chk("a256_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("a256_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("a256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("a256_handshakes", 128'(n_hs), 128'(15));
    chk("a256_latency", 128'(cyc_done), 128'(75));

    // Mode 3 aliases AES-128
    run_exp(2'd3, Key128, 100, 1'b0);
    chk_sched128("alias");
    chk("alias_handshakes", 128'(n_hs), 128'(11));

    // Random backpressure, ~30% ready duty
    run_exp(2'd0, Key128, 30, 1'b0);
    chk_sched128("bp");
    chk("bp_handshakes", 128'(n_hs), 128'(11));
    chk("bp_stall_stable", 128'(stall_bad), 128'(0));
    chk("bp_idx_seq", 128'(idx_bad), 128'(0));

    // start pulses and mode/key changes while running
    run_exp(2'd0, Key128, 100, 1'b1);
    chk_sched128("dist");
    chk("dist_handshakes", 128'(n_hs), 128'(11));
    chk("dist_latency", 128'(cyc_done), 128'(55));

    // Disabled mode on the limited instance
    @(negedge clk);
    start2 = 1'b1; mode = 2'd2; key_in = Key256;
    @(negedge clk);
    start2 = 1'b0;
    chk("lim_err_pulse", 128'(err2), 128'(1));
    chk("lim_busy_low", 128'(busy2), 128'(0));
    chk("main_err_quiet", 128'(err), 128'(0));
    @(negedge clk);
    chk("lim_err_one_cycle", 128'(err2), 128'(0));
    chk("lim_busy_still_low", 128'(busy2), 128'(0));

    // Reset in the middle of round 5
    @(negedge clk);
    start = 1'b1; mode = 2'd0; key_in = Key128; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rk_valid && rk_index == 4'd5) break;
      @(negedge clk);
    end
    chk("mid_reached_r5", 128'(rk_index), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_rk_data", rk_data, 128'(0));
    chk("mid_rst_rk_index", 128'(rk_index), 128'(0));
    rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_after_no_done", 128'(done), 128'(0));
    run_exp(2'd0, Key128, 100, 1'b0);
    chk_sched128("restart");
    chk("restart_latency", 128'(cyc_done), 128'(55));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative, runtime-selectable AES key schedule engine for AES-128, AES-192 and AES-256. It accepts a cipher key and a mode, then streams the full FIPS-197 round-key schedule, one 128-bit round key at a time, over a valid/ready handshake. It replaces the three fixed-width key-expansion instances that sit in front of the cipher and inverse-cipher cores with a single shared engine.

## Interface
- MODE_EN, 3'b111: per-mode enable mask. Bit 0 enables AES-128, bit 1 enables AES-192, bit 2 enables AES-256.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a new expansion; sampled only in IDLE.
- mode  in  2  key size: 0 = 128, 1 = 192, 2 = 256, 3 = 128 (alias). Sampled with start.
- key_in  in  256  cipher key, left-aligned. w[0] = key_in[255:224]. Unused low bits are ignored.
- busy  out  1  high from the cycle after start is accepted until done.
- rk_valid  out  1  rk_data/rk_index hold a complete round key.
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready.
- rk_data  out  128  round key: [127:96] = w[4r], [95:64] = w[4r+1], [63:32] = w[4r+2], [31:0] = w[4r+3].
- rk_index  out  4  round number r, from 0 to Nr.
- done  out  1  one-cycle pulse after round key Nr is accepted.
- err  out  1  one-cycle pulse when start requests a mode disabled by MODE_EN.

## Operation
- Mode parameters: Nk/Nr = 4/10 (128), 6/12 (192), 8/14 (256). Total words = 4·(Nr+1), i.e. 44, 52 or 60.
- States: IDLE, RUN, DONE.
- IDLE:
  - start with an enabled mode latches mode and key_in into an 8×32 sliding window, clears word index i and lane counter, and goes to RUN.
  - start with a disabled mode pulses err and stays in IDLE.
- RUN: each non-stalled cycle produces word w[i].
  - For i < Nk: w[i] is key word i.
  - Otherwise temp = w[i−1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i−Nk] ^ temp.
  - w[i] is shifted into the window and written into rk_data lane (i mod 4).
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- When lane 3 is written, rk_valid rises. Generation stalls while rk_valid is high.
- On handshake, rk_valid drops, rk_index increments and generation resumes the next cycle.
- After the handshake for r = Nr, the engine goes to DONE. DONE pulses done for one cycle and returns to IDLE.
- start is ignored while busy. mode and key_in changes during RUN have no effect.
- rk_ready while rk_valid is low has no effect.

## Timing
- Reset values: busy = 0, rk_valid = 0, rk_data = 0, rk_index = 0, done = 0, err = 0; state = IDLE.
- Reset asserted mid-expansion aborts immediately. No done pulse is produced.
- start accepted at edge E0: busy = 1 after E0. Words 0–3 are written at E1–E4; rk_valid = 1 after E4.
- Each round key needs 4 generation cycles plus at least 1 handshake cycle. Minimum 5 cycles per round key with rk_ready held high.
- Minimum start-to-done:
  - AES-128: 55 cycles.
  - AES-192: 65 cycles.
  - AES-256: 75 cycles.
- With rk_ready held low, rk_valid, rk_data and rk_index stay stable indefinitely.
- done is asserted in the cycle after the final handshake. busy falls with done. start is accepted again in the cycle after done.
- err is asserted in the cycle after the rejected start.

## Structure
- Package aes_pkg:
  - mode encoding constants;
  - Nk/Nr lookup functions;
  - Rcon table;
  - 32-bit word typedef;
  - RotWord function.
- Sub-module aes_sbox: combinational 8-bit forward S-box. Four instances form SubWord.
- All datapath logic (window, lane register, FSM) lives in the top module. No other sub-modules.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - rk_index 0 carries the key;
  - rk_index 1 = a0fafe1788542cb123a339392a6c7605;
  - rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done 55 cycles after start.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rk_index 12 = e98ba06f448c773c8ecc720401002202;
  - exactly 13 handshakes.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk_index 14 = fe4890d1e6188d0b046df344706c631e;
  - mode 3 with the A.1 key reproduces the AES-128 schedule.
- Random rk_ready backpressure (30 % duty): identical round-key sequence, and rk_data/rk_index never change while rk_valid && !rk_ready.
- start pulsed during RUN, and mode/key_in toggled mid-run: schedule unchanged.
- MODE_EN = 3'b011:
  - start with mode 2 gives an err pulse and busy stays 0.
- Reset and restart:
  - rst_n asserted at round 5 clears all outputs at once;
  - a new start then produces a correct schedule.
